// File: rtl/nios_ii_multi_timer_pkg.sv
// Multi-channel interval timer: shared register map
// and control/status bit positions.
package nios_ii_multi_timer_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam int CTRL_ITO     = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_START   = 2;
  localparam int CTRL_STOP    = 3;
  localparam int CTRL_DIV_LSB = 8;

  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

endpackage

// File: rtl/nios_ii_multi_timer_channel.sv
// One timer channel: prescaler, down-counter,
// RUN/TO flags, snapshot and its register file.
module nios_ii_timer_channel
  import nios_ii_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRESC_W      = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_status,
  input  logic        wr_control,
  input  logic        wr_period,
  input  logic        wr_snap,
  input  logic [31:0] writedata,
  input  logic [1:0]  reg_sel,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] RST_P =
    CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   snap;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] div;
  logic               ito;
  logic               cont;
  logic               run;
  logic               to;
  logic               force_reload;
  logic               start;
  logic               stop;
  logic               tick;
  logic               wrap;

  assign start = wr_control && writedata[CTRL_START];
  assign stop  = wr_control && writedata[CTRL_STOP];
  assign tick  = run && (presc == div);
  assign wrap  = tick && (count == '0);
  assign irq   = to && ito;

  // Software-visible registers and reload pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period       <= RST_P;
      ito          <= 1'b0;
      cont         <= 1'b0;
      div          <= '0;
      snap         <= '0;
      force_reload <= 1'b0;
    end else begin
      force_reload <= wr_period;
      if (wr_period)
        period <= writedata[CNT_W-1:0];
      if (wr_control) begin
        ito <= writedata[CTRL_ITO];
        cont <= writedata[CTRL_CONT];
        div <= writedata[CTRL_DIV_LSB +: PRESC_W];
      end
      if (wr_snap)
        snap <= count;
    end
  end

  // Prescaler: restarts on start, reload or stop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      presc <= '0;
    else if (start || wr_period)
      presc <= '0;
    else if (stop || force_reload || !run)
      presc <= '0;
    else if (tick)
      presc <= '0;
    else
      presc <= presc + PRESC_W'(1);
  end

  // Counter, RUN and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RST_P;
      run   <= 1'b0;
      to    <= 1'b0;
    end else begin
      if (force_reload)
        count <= period;
      else if (wrap)
        count <= period;
      else if (tick)
        count <= count - CNT_W'(1);

      if (start)
        run <= 1'b1;
      else if (stop || force_reload)
        run <= 1'b0;
      else if (wrap && !cont)
        run <= 1'b0;

      if (wrap)
        to <= 1'b1;
      else if (wr_status && writedata[STATUS_TO])
        to <= 1'b0;
    end
  end

  // Register read view for this channel
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_STATUS: begin
        rdata[STATUS_TO]  = to;
        rdata[STATUS_RUN] = run;
      end
      REG_CONTROL: begin
        rdata[CTRL_ITO]  = ito;
        rdata[CTRL_CONT] = cont;
        rdata[CTRL_DIV_LSB +: PRESC_W] = div;
      end
      REG_PERIOD: rdata[CNT_W-1:0] = period;
      REG_SNAP:   rdata[CNT_W-1:0] = snap;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/nios_ii_multi_timer.sv
// Avalon-MM multi-channel interval timer: address
// decode, channel array, registered read mux, irq OR.
module nios_ii_multi_timer
  import nios_ii_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESC_W      = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_CH)+1:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
);

  localparam int AW  = $clog2(NUM_CH) + 2;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CHW-1:0] ch_idx;
  logic [1:0]     reg_sel;
  logic           wr;
  logic [31:0]    ch_rdata [NUM_CH];
  logic [31:0]    rd_next;

  assign reg_sel = address[1:0];
  assign wr      = chipselect && !write_n;

  if (NUM_CH > 1) begin : g_idx
    assign ch_idx = address[AW-1:2];
  end else begin : g_one
    assign ch_idx = '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = wr && (ch_idx == CHW'(i));

    nios_ii_timer_channel #(
      .CNT_W        (CNT_W),
      .PRESC_W      (PRESC_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_status  (sel && reg_sel == REG_STATUS),
      .wr_control (sel && reg_sel == REG_CONTROL),
      .wr_period  (sel && reg_sel == REG_PERIOD),
      .wr_snap    (sel && reg_sel == REG_SNAP),
      .writedata  (writedata),
      .reg_sel    (reg_sel),
      .rdata      (ch_rdata[i]),
      .irq        (irq_vec[i])
    );
  end

  assign irq = |irq_vec;

  // Channel select for reads; absent channels read 0
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_idx == CHW'(i))
        rd_next = ch_rdata[i];
  end

  // Read data registered every clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

endmodule
